// File: rtl/dpi_ctx_sched.sv
// Time-multiplexes one DFA regex engine across NUM_FLOWS packet flows, saving and
// restoring each flow's engine state around round-robin burst grants.
module dpi_ctx_sched #(
  parameter  int NUM_FLOWS = 4,
  parameter  int STATE_W   = 11,
  parameter  int MAX_BURST = 16,
  localparam int FLOW_W    = $clog2(NUM_FLOWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_FLOWS-1:0]   s_valid,
  input  logic [8*NUM_FLOWS-1:0] s_data,
  input  logic [NUM_FLOWS-1:0]   s_last,
  output logic [NUM_FLOWS-1:0]   s_ready,
  output logic [7:0]             eng_char,
  output logic                   eng_char_vld,
  output logic [STATE_W-1:0]     eng_state_in,
  output logic                   eng_state_vld,
  input  logic [STATE_W-1:0]     eng_state_out,
  input  logic                   eng_accept,
  output logic                   res_vld,
  output logic [FLOW_W-1:0]      res_flow,
  output logic                   res_match
);

  localparam int          CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned NF    = NUM_FLOWS;

  typedef enum logic [1:0] {IDLE, RESTORE, STREAM, SAVE} state_t;

  state_t               state;
  logic [FLOW_W-1:0]    gnt;
  logic [FLOW_W-1:0]    rr_ptr;
  logic [FLOW_W-1:0]    pick;
  logic                 found;
  int unsigned          idx;
  logic [STATE_W-1:0]   ctx [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] match;
  logic [CNT_W-1:0]     burst_cnt;

  logic                 g_valid;
  logic                 g_last;
  logic [7:0]           g_data;
  logic                 burst_end;
  logic                 stream_exit;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NF; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NF) idx = idx - NF;
      if (!found && s_valid[idx[FLOW_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[FLOW_W-1:0];
      end
    end
  end

  assign g_valid     = s_valid[gnt];
  assign g_last      = s_last[gnt];
  assign g_data      = s_data[{gnt, 3'b000} +: 8];
  assign burst_end   = (burst_cnt == CNT_W'(MAX_BURST - 1));
  // A bubble, the packet's last byte, or the final byte of the burst all end the grant.
  assign stream_exit = !g_valid || g_last || burst_end;

  always_comb begin
    s_ready       = '0;
    eng_char      = '0;
    eng_char_vld  = 1'b0;
    eng_state_vld = 1'b0;
    eng_state_in  = '0;
    if (state == STREAM) begin
      s_ready[gnt] = g_valid;
      eng_char     = g_data;
      eng_char_vld = g_valid;
    end
    if (state == RESTORE) begin
      eng_state_vld = 1'b1;
      eng_state_in  = ctx[gnt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      match     <= '0;
      burst_cnt <= '0;
      res_vld   <= 1'b0;
      res_flow  <= '0;
      res_match <= 1'b0;
      for (int unsigned i = 0; i < NF; i++) ctx[i] <= '0;
    end else begin
      res_vld   <= 1'b0;
      res_flow  <= '0;
      res_match <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= pick;
            rr_ptr <= (pick == FLOW_W'(NUM_FLOWS - 1)) ? '0 : pick + 1'b1;
            state  <= RESTORE;
          end
        end
        RESTORE: begin
          burst_cnt <= '0;
          state     <= STREAM;
        end
        STREAM: begin
          if (g_valid) begin
            if (burst_cnt != CNT_W'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
            if (eng_accept) match[gnt] <= 1'b1;
          end
          if (stream_exit) begin
            state <= SAVE;
            if (g_valid && g_last) begin
              res_vld   <= 1'b1;
              res_flow  <= gnt;
              res_match <= match[gnt] | eng_accept;
            end
          end
        end
        SAVE: begin
          // res_vld doubles as the "last exit" flag for the cycle spent in SAVE.
          if (res_vld) begin
            ctx[gnt]   <= '0;
            match[gnt] <= 1'b0;
          end else if (burst_cnt != '0) begin
            ctx[gnt] <= eng_state_out;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dpi_ctx_sched.md
DPI_CTX_SCHED -- requirements
Module: dpi_ctx_sched

Time-multiplexes one DFA regex engine across several packet flows. Per-flow engine state is saved and restored across grants.

Interface
REQ-001 Parameter NUM_FLOWS, default 4: number of requesting flows (2..8).
REQ-002 Parameter STATE_W, default 11: DFA state width; matches engine state_in/state_out.
REQ-003 Parameter MAX_BURST, default 16: maximum bytes forwarded per grant (1..255).
REQ-004 clk  input  1: single clock; all logic on posedge clk.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 s_valid  input  NUM_FLOWS: per-flow byte available.
REQ-007 s_data  input  8*NUM_FLOWS: per-flow byte; flow i uses bits [8i+7:8i].
REQ-008 s_last  input  NUM_FLOWS: per-flow last byte of packet, qualified by s_valid.
REQ-009 s_ready  output  NUM_FLOWS: per-flow byte accepted this cycle when s_valid&s_ready.
REQ-010 eng_char  output  8: byte to engine char_in.
REQ-011 eng_char_vld  output  1: drives engine char_in_vld.
REQ-012 eng_state_in  output  STATE_W: drives engine state_in.
REQ-013 eng_state_vld  output  1: drives engine state_in_vld.
REQ-014 eng_state_out  input  STATE_W: engine current state.
REQ-015 eng_accept  input  1: engine accept_out (combinational, same cycle as eng_char_vld).
REQ-016 res_vld  output  1: one-cycle pulse, packet finished.
REQ-017 res_flow  output  clog2(NUM_FLOWS): flow of finished packet.
REQ-018 res_match  output  1: packet produced at least one accept.

Function
REQ-019 FSM states shall be IDLE, RESTORE, STREAM and SAVE.
REQ-020 IDLE: if any s_valid is set, the block shall grant a flow round-robin, starting the search at rr_ptr, and go to RESTORE; otherwise it shall stay in IDLE.
REQ-021 rr_ptr shall update on grant to (granted+1) mod NUM_FLOWS.
REQ-022 A sole requester shall be re-granted.
REQ-023 RESTORE (exactly 1 cycle): eng_state_vld=1 and eng_state_in=ctx[g]; eng_char_vld=0; s_ready=0; burst counter cleared; next state STREAM.
REQ-024 STREAM: s_ready[g] shall equal s_valid[g]; all other s_ready bits shall be 0.
REQ-025 STREAM: eng_char shall equal the s_data byte of flow g.
REQ-026 STREAM: eng_char_vld shall equal s_valid[g]; one byte per cycle maximum.
REQ-027 Accepted byte with eng_accept=1: match[g] shall be set (sticky).
REQ-028 STREAM shall exit to SAVE when the accepted byte has s_last, or the burst count reaches MAX_BURST, or s_valid[g]=0 (bubble ends the grant).
REQ-029 SAVE (1 cycle), non-last exit: ctx[g] shall be loaded with eng_state_out, which reflects the final byte.
REQ-030 SAVE, last exit: ctx[g] shall be cleared to 0.
REQ-031 SAVE, last exit: res_vld=1, res_flow=g, and res_match=match[g] including the last byte's accept; match[g] shall then be cleared.
REQ-032 SAVE shall go to IDLE; grant-to-grant overhead shall be 3 cycles (IDLE, RESTORE, SAVE).
REQ-033 Outside STREAM: eng_char_vld=0 and s_ready all 0.
REQ-034 Outside RESTORE: eng_state_vld=0 and eng_state_in=0.
REQ-035 A zero-byte grant (s_valid dropped before STREAM) shall still perform SAVE with ctx unchanged in value.
REQ-036 res_vld shall be 0 in all states other than SAVE with a last exit.
REQ-037 The burst counter shall saturate at MAX_BURST and shall not wrap.
REQ-038 Contexts of non-granted flows shall never be modified.

Reset
REQ-039 On rst_n=0, immediately and asynchronously: FSM=IDLE, rr_ptr=0, all ctx=0, all match=0, burst counter=0.
REQ-040 On rst_n=0, immediately and asynchronously: all outputs=0.
REQ-041 Reset mid-STREAM shall abandon the packet with no res_vld pulse; after release, operation shall restart from IDLE with cleared contexts.

Verification
REQ-042 Single flow 0, bytes "CCC" with s_last on the third byte -> sequence RESTORE(state_in=0), 3 STREAM cycles, SAVE; res_vld=1, res_flow=0, res_match=1; ctx[0]=0.
REQ-043 Flows 0 and 1 each continuously valid, MAX_BURST=4 -> grants alternate 0,1,0,1; each grant forwards exactly 4 bytes; RESTORE restores the state saved at that flow's previous SAVE.
REQ-044 Flow 2 sends "C", drops s_valid, flow 3 sends 5 bytes, then flow 2 sends "C"+last -> flow 2 saved state=3 is restored; res_match for flow 2=1.
REQ-045 All 4 flows request simultaneously after reset -> grant order 0,1,2,3,0.
REQ-046 rst_n asserted during STREAM on flow 1 -> outputs 0 in the same cycle; no res_vld; after release, flow 1 restarts with eng_state_in=0.
